// File: rtl/ova_tile_splitter.sv
// ova_tile_splitter: buffers one image, then streams overlapping SIZE x SIZE tiles over valid/ready
module ova_tile_splitter #(
   parameter int NUM_BLOCK_ROOT = 4,
   parameter int SIZE           = 9,
   parameter int OVERLAP        = 3,
   parameter int DATA_W         = 64,
   localparam int STEP    = SIZE - OVERLAP,
   localparam int IMG_DIM = NUM_BLOCK_ROOT*SIZE - (NUM_BLOCK_ROOT-1)*OVERLAP,
   localparam int NT      = NUM_BLOCK_ROOT*NUM_BLOCK_ROOT,
   localparam int DEPTH   = IMG_DIM*IMG_DIM,
   localparam int AW      = DEPTH > 1 ? $clog2(DEPTH) : 1,
   localparam int TW      = NT > 1 ? $clog2(NT) : 1,
   localparam int RW      = SIZE > 1 ? $clog2(SIZE) : 1,
   localparam int BW      = NUM_BLOCK_ROOT > 1 ? $clog2(NUM_BLOCK_ROOT) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [TW-1:0]     out_tile,
   output logic [RW-1:0]     out_row,
   output logic [RW-1:0]     out_col,
   output logic              out_tile_last,
   output logic              out_img_last,
   output logic              busy
);
   typedef enum logic [1:0] {LOAD, FETCH, EMIT} state_t;
   state_t state_q, state_d;
   logic [AW-1:0] waddr_q, waddr_d, raddr;
   logic [BW-1:0] tr_q, tr_d, tc_q, tc_d, tr_n, tc_n, tr_a, tc_a;
   logic [RW-1:0] r_q, r_d, c_q, c_d, r_n, c_n, r_a, c_a;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rdata_q;
   logic we, re, fire, c_w, r_w, tc_w, tr_w, tile_last, img_last;
   assign fire      = state_q == EMIT && out_ready;
   assign c_w       = c_q == RW'(SIZE-1);
   assign r_w       = r_q == RW'(SIZE-1);
   assign tc_w      = tc_q == BW'(NUM_BLOCK_ROOT-1);
   assign tr_w      = tr_q == BW'(NUM_BLOCK_ROOT-1);
   assign tile_last = c_w && r_w;
   assign img_last  = tile_last && tc_w && tr_w;
   assign c_n  = c_w ? '0 : c_q + 1'b1;
   assign r_n  = c_w ? (r_w ? '0 : r_q + 1'b1) : r_q;
   assign tc_n = tile_last ? (tc_w ? '0 : tc_q + 1'b1) : tc_q;
   assign tr_n = (tile_last && tc_w) ? (tr_w ? '0 : tr_q + 1'b1) : tr_q;
   assign tr_a = state_q == FETCH ? tr_q : tr_n;
   assign tc_a = state_q == FETCH ? tc_q : tc_n;
   assign r_a  = state_q == FETCH ? r_q : r_n;
   assign c_a  = state_q == FETCH ? c_q : c_n;
   assign raddr = (AW'(tr_a)*AW'(STEP) + AW'(r_a))*AW'(IMG_DIM) + AW'(tc_a)*AW'(STEP) + AW'(c_a);
   assign in_ready      = state_q == LOAD;
   assign out_valid     = state_q == EMIT;
   assign busy          = state_q != LOAD;
   assign out_data      = rdata_q;
   assign out_tile      = TW'(tr_q)*TW'(NUM_BLOCK_ROOT) + TW'(tc_q);
   assign out_row       = r_q;
   assign out_col       = c_q;
   assign out_tile_last = out_valid && tile_last;
   assign out_img_last  = out_valid && img_last;
   // next state: load sequencing, single fetch cycle, tile walk on each output handshake
   always_comb begin
      state_d = state_q;
      waddr_d = waddr_q;
      tr_d    = tr_q;
      tc_d    = tc_q;
      r_d     = r_q;
      c_d     = c_q;
      we      = 1'b0;
      re      = 1'b0;
      if (state_q == LOAD && in_valid) begin
         we      = 1'b1;
         waddr_d = waddr_q == AW'(DEPTH-1) ? '0 : waddr_q + 1'b1;
         state_d = waddr_q == AW'(DEPTH-1) ? FETCH : LOAD;
      end else if (state_q == FETCH) begin
         re      = 1'b1;
         state_d = EMIT;
      end else if (fire) begin
         tr_d    = tr_n;
         tc_d    = tc_n;
         r_d     = r_n;
         c_d     = c_n;
         re      = !img_last;
         state_d = img_last ? LOAD : EMIT;
      end
   end
   // state and counter registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= LOAD;
         waddr_q <= '0;
         tr_q    <= '0;
         tc_q    <= '0;
         r_q     <= '0;
         c_q     <= '0;
      end else begin
         state_q <= state_d;
         waddr_q <= waddr_d;
         tr_q    <= tr_d;
         tc_q    <= tc_d;
         r_q     <= r_d;
         c_q     <= c_d;
      end
   end
   // image buffer write port; contents survive reset
   always_ff @(posedge clk) begin
      if (we) mem[waddr_q] <= in_data;
   end
   // synchronous read; register holds while stalled or idle
   always_ff @(posedge clk) begin
      if (reset) rdata_q <= '0;
      else if (re) rdata_q <= mem[raddr];
   end
endmodule

// File: tb/tb_ova_tile_splitter.sv
// tb_ova_tile_splitter: scoreboard, table and corner-sequence checks for ova_tile_splitter
module tb_ova_tile_splitter;
   localparam int NBR = 4, S = 9, OV = 3, STP = S - OV;
   localparam int IMG = NBR*S - (NBR-1)*OV, NT = NBR*NBR, PIX = IMG*IMG, TOT = NT*S*S;
   typedef struct {logic [63:0] data; int tile, row, col; bit tl, il;} exp_t;
   typedef struct {int tile, row, col; logic [63:0] data; bit tl, il;} vec_t;
   logic clk, reset, in_valid, in_ready, out_valid, out_ready, out_tile_last, out_img_last, busy;
   logic [63:0] in_data, out_data;
   logic [3:0] out_tile, out_row, out_col;
   int checks = 0, errors = 0, cyc = 0;
   int img_writes, last_wr, hs_img, first_hs, last_hs;
   bit seen_first, stall, cap_en;
   logic [63:0] first_data;
   logic [63:0] s_data;
   logic [3:0] s_tile, s_row, s_col;
   logic s_tl, s_il;
   exp_t exp_q[$];
   logic [63:0] cap_d [NT][S][S];
   bit cap_tl [NT][S][S];
   bit cap_il [NT][S][S];
   vec_t tbl[10];

   ova_tile_splitter dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tile(out_tile),
      .out_row(out_row), .out_col(out_col), .out_tile_last(out_tile_last),
      .out_img_last(out_img_last), .busy(busy)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // expected stream built straight from the tiling rule over the loaded image
   task automatic build_expected(input logic [63:0] base);
      exp_t e;
      exp_q.delete();
      for (int tr = 0; tr < NBR; tr++)
         for (int tc = 0; tc < NBR; tc++)
            for (int r = 0; r < S; r++)
               for (int c = 0; c < S; c++) begin
                  e.data = base + 64'(IMG*(tr*STP + r) + tc*STP + c);
                  e.tile = tr*NBR + tc;
                  e.row  = r;
                  e.col  = c;
                  e.tl   = (r == S-1) && (c == S-1);
                  e.il   = e.tl && (e.tile == NT-1);
                  exp_q.push_back(e);
               end
   endtask

   // monitor: sampled on the falling edge, away from the active edge
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (reset) stall = 0;
      else begin
         if (in_valid && in_ready) begin
            img_writes++;
            last_wr = cyc;
         end
         if (stall) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, s_data);
            chk("hold_tile", out_tile, s_tile);
            chk("hold_row", out_row, s_row);
            chk("hold_col", out_col, s_col);
            chk("hold_tl", out_tile_last, s_tl);
            chk("hold_il", out_img_last, s_il);
         end
         stall  = out_valid && !out_ready;
         s_data = out_data;
         s_tile = out_tile;
         s_row  = out_row;
         s_col  = out_col;
         s_tl   = out_tile_last;
         s_il   = out_img_last;
         if (out_valid) begin
            if (!seen_first) begin
               seen_first = 1;
               chk("latency", 64'(cyc - last_wr), 2);
            end
            chk("busy_emit", busy, 1);
            chk("in_ready_emit", in_ready, 0);
            if (out_ready) begin
               if (exp_q.size() == 0) chk("unexpected_output", 1, 0);
               else begin
                  e = exp_q.pop_front();
                  chk("data", out_data, e.data);
                  chk("tile", out_tile, 64'(e.tile));
                  chk("row", out_row, 64'(e.row));
                  chk("col", out_col, 64'(e.col));
                  chk("tile_last", out_tile_last, e.tl);
                  chk("img_last", out_img_last, e.il);
               end
               if (hs_img == 0) begin
                  first_hs = cyc;
                  first_data = out_data;
               end
               last_hs = cyc;
               hs_img++;
               if (cap_en && out_tile < NT && out_row < S && out_col < S) begin
                  cap_d[out_tile][out_row][out_col]  = out_data;
                  cap_tl[out_tile][out_row][out_col] = out_tile_last;
                  cap_il[out_tile][out_row][out_col] = out_img_last;
               end
            end
         end
      end
   end

   // feeds PIX raster elements base+index, optionally with idle gaps; called at posedge+1
   task automatic load_image(input logic [63:0] base, input bit gaps);
      img_writes = 0;
      hs_img = 0;
      seen_first = 0;
      build_expected(base);
      for (int b = 0; b < 5000 && img_writes < PIX; b++) begin
         in_valid = !(gaps && $urandom_range(3) == 0);
         in_data  = base + 64'(img_writes);
         @(posedge clk);
         #1;
      end
      in_valid = 0;
      chk("load_done", 64'(img_writes), PIX);
   endtask

   // drains the expected stream; rnd randomises out_ready, junk drives in_valid during EMIT
   task automatic run_stream(input bit rnd, input bit junk);
      int b;
      for (b = 0; b < 20000 && exp_q.size() > 0; b++) begin
         out_ready = rnd ? 1'($urandom_range(1)) : 1'b1;
         in_valid  = junk && exp_q.size() > 4;
         in_data   = {$urandom, $urandom};
         @(posedge clk);
         #1;
      end
      if (b == 20000) chk("stream_timeout", 64'(exp_q.size()), 0);
      out_ready = 1;
      in_valid = 0;
      @(negedge clk);
      chk("in_ready_after", in_ready, 1);
      chk("out_valid_after", out_valid, 0);
      chk("writes_per_image", 64'(img_writes), PIX);
      chk("handshakes", 64'(hs_img), TOT);
      @(posedge clk);
      #1;
   endtask

   initial begin
      tbl[0] = '{0, 0, 0, 64'd0, 1'b0, 1'b0};
      tbl[1] = '{0, 0, 8, 64'd8, 1'b0, 1'b0};
      tbl[2] = '{1, 0, 0, 64'd6, 1'b0, 1'b0};
      tbl[3] = '{4, 0, 0, 64'd162, 1'b0, 1'b0};
      tbl[4] = '{15, 8, 8, 64'd728, 1'b1, 1'b1};
      tbl[5] = '{5, 2, 3, 64'd225, 1'b0, 1'b0};
      tbl[6] = '{3, 0, 8, 64'd26, 1'b0, 1'b0};
      tbl[7] = '{12, 8, 0, 64'd702, 1'b0, 1'b0};
      tbl[8] = '{10, 4, 4, 64'd448, 1'b0, 1'b0};
      tbl[9] = '{0, 8, 8, 64'd224, 1'b1, 1'b0};
      for (int t = 0; t < NT; t++)
         for (int r = 0; r < S; r++)
            for (int c = 0; c < S; c++) cap_d[t][r][c] = '1;
      reset = 1;
      in_valid = 0;
      in_data = 0;
      out_ready = 1;
      cap_en = 0;
      stall = 0;
      last_wr = 0;
      repeat (3) @(posedge clk);
      #1 reset = 0;
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_tile", out_tile, 0);
      @(posedge clk);
      #1;
      cap_en = 1;
      load_image(0, 0);
      run_stream(0, 0);
      cap_en = 0;
      chk("no_gaps", 64'(last_hs - first_hs), TOT-1);
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("tbl%0d_data", i), cap_d[tbl[i].tile][tbl[i].row][tbl[i].col], tbl[i].data);
         chk($sformatf("tbl%0d_tl", i), cap_tl[tbl[i].tile][tbl[i].row][tbl[i].col], tbl[i].tl);
         chk($sformatf("tbl%0d_il", i), cap_il[tbl[i].tile][tbl[i].row][tbl[i].col], tbl[i].il);
      end
      for (int r = 0; r < S; r++)
         for (int k = 0; k < OV; k++) begin
            chk("ovl_h", cap_d[1][r][k], cap_d[0][r][STP+k]);
            chk("ovl_v", cap_d[4][k][r], cap_d[0][STP+k][r]);
         end
      load_image(0, 1);
      run_stream(1, 1);
      load_image(1000, 1);
      run_stream(0, 0);
      chk("second_first", first_data, 1000);
      load_image(0, 1);
      for (int b = 0; b < 5000 && hs_img < 500; b++) begin
         @(posedge clk);
         #1;
      end
      chk("reached_500", 64'(hs_img >= 500), 1);
      reset = 1;
      out_ready = 0;
      @(posedge clk);
      #1;
      reset = 0;
      out_ready = 1;
      exp_q.delete();
      @(negedge clk);
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_in_ready", in_ready, 1);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_data", out_data, 0);
      chk("mid_rst_tile", out_tile, 0);
      chk("mid_rst_row", out_row, 0);
      chk("mid_rst_col", out_col, 0);
      chk("mid_rst_tl", out_tile_last, 0);
      chk("mid_rst_il", out_img_last, 0);
      @(posedge clk);
      #1;
      load_image(2000, 0);
      run_stream(0, 0);
      chk("reload_first", first_data, 2000);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
